controle_elevador_param: RTL and testbench

Parametrised elevator core for N floors. It replaces the fixed 4-floor switch selector with latched per-floor call requests, SCAN-style direction scheduling, timed floor travel and a timed door.
- Absorbs the people counter: a saturating count with a capacity alarm, accepted only while the door is open.
- Sits between the debounced inputs (buttons/switches) and the display manager. Drives floor, direction flags, count and alarm.

---
 rtl/controle_elevador_param_pkg.sv | 16 +
 rtl/controle_elevador_param_contador_pessoas.sv | 58 +++++
 rtl/controle_elevador_param.sv | 227 ++++++++++++++++++++++
 tb/tb_controle_elevador_param.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_elevador_param_pkg.sv
// Shared types and constants for the parametrised elevator core.
package controle_elevador_param_pkg;

   // Controller states; PARADO and PORTA_ABERTA both count as "stopped"
   typedef enum logic [1:0] {
      PARADO       = 2'd0,
      SUBINDO      = 2'd1,
      DESCENDO     = 2'd2,
      PORTA_ABERTA = 2'd3
   } estado_t;

   // Last travel direction, used to break ties when calls exist both ways
   localparam logic DIR_SOBE  = 1'b1;
   localparam logic DIR_DESCE = 1'b0;

endpackage

// File: rtl/controle_elevador_param_contador_pessoas.sv
// Saturating occupant counter. Pulses count only while enabled (door open);
// o_aceito flags a pulse that was honoured so the door timer can restart.
module contador_pessoas
   import controle_elevador_param_pkg::*;
#(
   parameter int CAPACIDADE = 3,
   localparam int LC = $clog2(CAPACIDADE + 1)
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_habilita,
   input  logic          i_entra,
   input  logic          i_sai,
   output logic [LC-1:0] o_quantidade,
   output logic          o_alerta,
   output logic          o_aceito
);

   localparam logic [LC-1:0] MAXIMO = LC'(CAPACIDADE);

   logic [LC-1:0] r_quantidade;
   logic          r_alerta;
   logic          w_cheio;
   logic          w_vazio;
   logic          w_soma;
   logic          w_subtrai;
   logic [LC-1:0] w_proxima;

   // Decide whether the pulse is honoured and what the next count is
   always_comb begin
      w_cheio   = (r_quantidade == MAXIMO);
      w_vazio   = (r_quantidade == '0);
      w_soma    = i_habilita & i_entra & ~i_sai & ~w_cheio;
      w_subtrai = i_habilita & i_sai & ~i_entra & ~w_vazio;
      o_aceito  = w_soma | w_subtrai | (i_habilita & i_entra & i_sai);
      w_proxima = r_quantidade;
      if (w_soma) begin
         w_proxima = r_quantidade + 1'b1;
      end else if (w_subtrai) begin
         w_proxima = r_quantidade - 1'b1;
      end
   end

   // Count register; alarm reflects the post-update count
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_quantidade <= '0;
         r_alerta     <= 1'b0;
      end else begin
         r_quantidade <= w_proxima;
         r_alerta     <= (w_proxima == MAXIMO);
      end
   end

   assign o_quantidade = r_quantidade;
   assign o_alerta     = r_alerta;

endmodule

// File: rtl/controle_elevador_param.sv
// Elevator core: latched per-floor calls, SCAN-style direction choice,
// timed floor travel and a timed door, plus the occupant counter.
module controle_elevador_param
   import controle_elevador_param_pkg::*;
#(
   parameter int N_ANDARES   = 4,
   parameter int CAPACIDADE  = 3,
   parameter int TEMPO_ANDAR = 8,
   parameter int TEMPO_PORTA = 16,
   localparam int LA = $clog2(N_ANDARES),
   localparam int LC = $clog2(CAPACIDADE + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_ANDARES-1:0] chamada,
   input  logic                 pessoa_entra,
   input  logic                 pessoa_sai,
   output logic [LA-1:0]        andar_atual,
   output logic                 subindo,
   output logic                 descendo,
   output logic                 parado,
   output logic                 porta_aberta,
   output logic [N_ANDARES-1:0] pedidos_pendentes,
   output logic [LC-1:0]        quantidade_pessoas,
   output logic                 alerta_capacidade
);

   localparam int TEMPO_MAX = (TEMPO_ANDAR > TEMPO_PORTA) ? TEMPO_ANDAR : TEMPO_PORTA;
   localparam int LT        = $clog2(TEMPO_MAX + 1);

   localparam logic [LT-1:0] CARGA_ANDAR = LT'(TEMPO_ANDAR - 1);
   localparam logic [LT-1:0] CARGA_PORTA = LT'(TEMPO_PORTA - 1);
   localparam logic [LA-1:0] ANDAR_TOPO  = LA'(N_ANDARES - 1);

   estado_t              r_estado;
   logic [LA-1:0]        r_andar;
   logic [LT-1:0]        r_timer;
   logic [N_ANDARES-1:0] r_pedidos;
   logic                 r_dir;
   logic                 r_subindo;
   logic                 r_descendo;
   logic                 r_parado;
   logic                 r_porta;

   logic [N_ANDARES-1:0] w_efetivo;
   logic [N_ANDARES-1:0] w_um_aqui;
   logic [N_ANDARES-1:0] w_um_cima;
   logic [N_ANDARES-1:0] w_um_baixo;
   logic [N_ANDARES-1:0] w_mask_acima;
   logic [N_ANDARES-1:0] w_mask_abaixo;
   logic [N_ANDARES-1:0] w_mask_alem_cima;
   logic [N_ANDARES-1:0] w_mask_alem_baixo;

   logic w_aqui;
   logic w_chamada_aqui;
   logic w_acima;
   logic w_abaixo;
   logic w_chega_cima;
   logic w_chega_baixo;
   logic w_alem_cima;
   logic w_alem_baixo;
   logic w_habilita;
   logic w_aceito;

   estado_t              w_prox_estado;
   logic [LA-1:0]        w_prox_andar;
   logic [LT-1:0]        w_prox_timer;
   logic [N_ANDARES-1:0] w_prox_pedidos;
   logic                 w_prox_dir;

   // Floor masks relative to the current floor and its neighbours
   always_comb begin
      w_um_aqui         = '0;
      w_um_cima         = '0;
      w_um_baixo        = '0;
      w_mask_acima      = '0;
      w_mask_abaixo     = '0;
      w_mask_alem_cima  = '0;
      w_mask_alem_baixo = '0;
      for (int unsigned i = 0; i < N_ANDARES; i++) begin
         w_um_aqui[i]         = (i == 32'(r_andar));
         w_um_cima[i]         = (i == 32'(r_andar) + 32'd1);
         w_um_baixo[i]        = (i + 32'd1 == 32'(r_andar));
         w_mask_acima[i]      = (i > 32'(r_andar));
         w_mask_abaixo[i]     = (i < 32'(r_andar));
         w_mask_alem_cima[i]  = (i > 32'(r_andar) + 32'd1);
         w_mask_alem_baixo[i] = (i + 32'd1 < 32'(r_andar));
      end
   end

   // Calls act on the same edge they are sampled
   always_comb begin
      w_efetivo      = r_pedidos | chamada;
      w_aqui         = |(w_efetivo & w_um_aqui);
      w_chamada_aqui = |(chamada & w_um_aqui);
      w_acima        = |(w_efetivo & w_mask_acima);
      w_abaixo       = |(w_efetivo & w_mask_abaixo);
      w_chega_cima   = |(w_efetivo & w_um_cima);
      w_chega_baixo  = |(w_efetivo & w_um_baixo);
      w_alem_cima    = |(w_efetivo & w_mask_alem_cima);
      w_alem_baixo   = |(w_efetivo & w_mask_alem_baixo);
   end

   assign w_habilita = (r_estado == PORTA_ABERTA);

   contador_pessoas #(
      .CAPACIDADE(CAPACIDADE)
   ) u_contador (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_habilita   (w_habilita),
      .i_entra      (pessoa_entra),
      .i_sai        (pessoa_sai),
      .o_quantidade (quantidade_pessoas),
      .o_alerta     (alerta_capacidade),
      .o_aceito     (w_aceito)
   );

   // Next-state decision for the travel/door controller
   always_comb begin
      w_prox_estado  = r_estado;
      w_prox_andar   = r_andar;
      w_prox_timer   = r_timer;
      w_prox_pedidos = w_efetivo;
      w_prox_dir     = r_dir;
      case (r_estado)
         PARADO: begin
            if (w_aqui) begin
               w_prox_estado  = PORTA_ABERTA;
               w_prox_pedidos = w_efetivo & ~w_um_aqui;
               w_prox_timer   = CARGA_PORTA;
            end else if (w_acima && (!w_abaixo || r_dir == DIR_SOBE)) begin
               w_prox_estado = SUBINDO;
               w_prox_timer  = CARGA_ANDAR;
            end else if (w_abaixo) begin
               w_prox_estado = DESCENDO;
               w_prox_timer  = CARGA_ANDAR;
            end
         end
         SUBINDO: begin
            if (r_timer != '0) begin
               w_prox_timer = r_timer - 1'b1;
            end else if (r_andar != ANDAR_TOPO) begin
               w_prox_andar = r_andar + 1'b1;
               w_prox_dir   = DIR_SOBE;
               if (w_chega_cima) begin
                  w_prox_estado  = PORTA_ABERTA;
                  w_prox_pedidos = w_efetivo & ~w_um_cima;
                  w_prox_timer   = CARGA_PORTA;
               end else if (w_alem_cima) begin
                  w_prox_timer = CARGA_ANDAR;
               end else begin
                  w_prox_estado = PARADO;
               end
            end else begin
               w_prox_estado = PARADO;
            end
         end
         DESCENDO: begin
            if (r_timer != '0) begin
               w_prox_timer = r_timer - 1'b1;
            end else if (r_andar != '0) begin
               w_prox_andar = r_andar - 1'b1;
               w_prox_dir   = DIR_DESCE;
               if (w_chega_baixo) begin
                  w_prox_estado  = PORTA_ABERTA;
                  w_prox_pedidos = w_efetivo & ~w_um_baixo;
                  w_prox_timer   = CARGA_PORTA;
               end else if (w_alem_baixo) begin
                  w_prox_timer = CARGA_ANDAR;
               end else begin
                  w_prox_estado = PARADO;
               end
            end else begin
               w_prox_estado = PARADO;
            end
         end
         PORTA_ABERTA: begin
            // A call for this floor is absorbed by keeping the door open
            w_prox_pedidos = w_efetivo & ~w_um_aqui;
            if (w_chamada_aqui || w_aceito) begin
               w_prox_timer = CARGA_PORTA;
            end else if (r_timer == '0) begin
               w_prox_estado = PARADO;
            end else begin
               w_prox_timer = r_timer - 1'b1;
            end
         end
         default: begin
            w_prox_estado = PARADO;
         end
      endcase
   end

   // State, position, requests and registered status flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado   <= PARADO;
         r_andar    <= '0;
         r_timer    <= '0;
         r_pedidos  <= '0;
         r_dir      <= DIR_SOBE;
         r_subindo  <= 1'b0;
         r_descendo <= 1'b0;
         r_parado   <= 1'b1;
         r_porta    <= 1'b0;
      end else begin
         r_estado   <= w_prox_estado;
         r_andar    <= w_prox_andar;
         r_timer    <= w_prox_timer;
         r_pedidos  <= w_prox_pedidos;
         r_dir      <= w_prox_dir;
         r_subindo  <= (w_prox_estado == SUBINDO);
         r_descendo <= (w_prox_estado == DESCENDO);
         r_parado   <= (w_prox_estado == PARADO) || (w_prox_estado == PORTA_ABERTA);
         r_porta    <= (w_prox_estado == PORTA_ABERTA);
      end
   end

   assign andar_atual       = r_andar;
   assign subindo           = r_subindo;
   assign descendo          = r_descendo;
   assign parado            = r_parado;
   assign porta_aberta      = r_porta;
   assign pedidos_pendentes = r_pedidos;

endmodule

// File: tb/tb_controle_elevador_param.sv
// Self-checking bench for controle_elevador_param (4 floors, capacity 3).
module tb_controle_elevador_param;

   localparam int N   = 4;
   localparam int CAP = 3;
   localparam int TA  = 4;
   localparam int TP  = 6;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] chamada;
   logic         entra;
   logic         sai;
   logic [1:0]   andar;
   logic         sub;
   logic         desc;
   logic         par;
   logic         porta;
   logic [N-1:0] pend;
   logic [1:0]   qtd;
   logic         alerta;
   logic [12:0]  obs;

   int checks = 0;
   int fails  = 0;

   // Reference model: position, pending calls, remaining cycles in phase
   int           m_floor;
   int           m_cnt;
   int           m_left;
   bit           m_moving;
   bit           m_up;
   bit           m_door;
   bit           m_last_up;
   logic [N-1:0] m_pend;

   controle_elevador_param #(
      .N_ANDARES   (N),
      .CAPACIDADE  (CAP),
      .TEMPO_ANDAR (TA),
      .TEMPO_PORTA (TP)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .chamada            (chamada),
      .pessoa_entra       (entra),
      .pessoa_sai         (sai),
      .andar_atual        (andar),
      .subindo            (sub),
      .descendo           (desc),
      .parado             (par),
      .porta_aberta       (porta),
      .pedidos_pendentes  (pend),
      .quantidade_pessoas (qtd),
      .alerta_capacidade  (alerta)
   );

   always #5 clock = ~clock;

   assign obs = {andar, sub, desc, par, porta, pend, qtd, alerta};

   function automatic logic [12:0] exp_vec();
      return {2'(m_floor), m_moving && m_up, m_moving && !m_up, !m_moving, m_door,
              m_pend, 2'(m_cnt), (m_cnt == CAP)};
   endfunction

   function automatic bit any_above(logic [N-1:0] v, int f);
      for (int i = f + 1; i < N; i++) if (v[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit any_below(logic [N-1:0] v, int f);
      for (int i = 0; i < f; i++) if (v[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_floor = 0; m_cnt = 0; m_left = 0; m_moving = 0;
      m_up = 1; m_door = 0; m_last_up = 1; m_pend = '0;
   endtask

   task automatic model_edge(logic [N-1:0] ch, bit en, bit sa);
      logic [N-1:0] eff;
      bit           acc;
      eff = m_pend | ch;
      acc = 0;
      if (m_door) begin
         if (en && sa) acc = 1;
         else if (en && m_cnt < CAP) begin m_cnt++; acc = 1; end
         else if (sa && !en && m_cnt > 0) begin m_cnt--; acc = 1; end
         eff[m_floor] = 1'b0;
         m_pend = eff;
         if (ch[m_floor] || acc) m_left = TP;
         else begin
            m_left--;
            if (m_left == 0) m_door = 0;
         end
      end else if (m_moving) begin
         m_pend = eff;
         m_left--;
         if (m_left == 0) begin
            m_floor += m_up ? 1 : -1;
            m_last_up = m_up;
            if (eff[m_floor]) begin
               m_pend[m_floor] = 1'b0; m_moving = 0; m_door = 1; m_left = TP;
            end else if (m_up ? any_above(eff, m_floor) : any_below(eff, m_floor)) begin
               m_left = TA;
            end else begin
               m_moving = 0;
            end
         end
      end else begin
         m_pend = eff;
         if (eff[m_floor]) begin
            m_pend[m_floor] = 1'b0; m_door = 1; m_left = TP;
         end else if (any_above(eff, m_floor) || any_below(eff, m_floor)) begin
            m_moving = 1;
            m_up = any_above(eff, m_floor) && (!any_below(eff, m_floor) || m_last_up);
            m_left = TA;
         end
      end
   endtask

   task automatic step(logic [N-1:0] ch, bit en, bit sa);
      chamada = ch; entra = en; sai = sa;
      @(posedge clock);
      #1;
      model_edge(ch, en, sa);
      chamada = '0; entra = 1'b0; sai = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs !== 13'b00_0_0_1_0_0000_00_0) begin
         fails++; $display("FAIL reset_state got %b expected %b", obs, 13'b00_0_0_1_0_0000_00_0);
      end
      checks++;
      if (obs !== exp_vec()) begin
         fails++; $display("FAIL reset_model got %b expected %b", obs, exp_vec());
      end
   endtask

   task automatic test_up_travel();
      int opened = 0;
      do_reset();
      step(4'b1000, 0, 0);
      checks++;
      if (sub !== 1'b1) begin fails++; $display("FAIL up_start subindo got %b expected 1", sub); end
      for (int k = 0; k < 30; k++) begin
         step('0, 0, 0);
         checks++;
         if (obs !== exp_vec()) begin
            fails++; $display("FAIL up_model k=%0d got %b expected %b", k, obs, exp_vec());
         end
         if (porta) opened++;
         if (k == 3 || k == 7 || k == 11) begin
            checks++;
            if (andar !== 2'((k + 1) / 4)) begin
               fails++; $display("FAIL up_floor k=%0d got %0d expected %0d", k, andar, (k + 1) / 4);
            end
         end
      end
      checks++;
      if (opened != TP) begin fails++; $display("FAIL up_door_cycles got %0d expected %0d", opened, TP); end
      checks++;
      if (pend !== 4'b0000 || par !== 1'b1) begin
         fails++; $display("FAIL up_end got pend=%b parado=%b expected 0000/1", pend, par);
      end
   endtask

   task automatic test_direction_memory();
      int  served[$];
      bit  prev = 0;
      do_reset();
      step(4'b0100, 0, 0);
      for (int k = 0; k < 3; k++) step('0, 0, 0);
      step(4'b1001, 0, 0);
      for (int k = 0; k < 80; k++) begin
         step('0, 0, 0);
         checks++;
         if (obs !== exp_vec()) begin
            fails++; $display("FAIL dir_model k=%0d got %b expected %b", k, obs, exp_vec());
         end
         if (porta && !prev) served.push_back(int'(andar));
         prev = porta;
      end
      checks++;
      if (served.size() != 3 || served[0] != 2 || served[1] != 3 || served[2] != 0) begin
         fails++;
         $display("FAIL dir_order got %0d stops (first %0d) expected 3 stops 2,3,0",
                  served.size(), (served.size() > 0) ? served[0] : -1);
      end
   endtask

   task automatic test_current_floor();
      int openc = 1;
      do_reset();
      step(4'b0001, 0, 0);
      checks++;
      if (porta !== 1'b1) begin fails++; $display("FAIL here_open got %b expected 1", porta); end
      step('0, 0, 0);
      step('0, 0, 0);
      step(4'b0001, 0, 0);
      checks++;
      if (pend !== 4'b0000 || porta !== 1'b1) begin
         fails++; $display("FAIL here_relatch got pend=%b porta=%b expected 0000/1", pend, porta);
      end
      for (int k = 0; k < 20; k++) begin
         step('0, 0, 0);
         checks++;
         if (obs !== exp_vec()) begin
            fails++; $display("FAIL here_model k=%0d got %b expected %b", k, obs, exp_vec());
         end
         if (porta) openc++;
         else break;
      end
      checks++;
      if (openc != TP) begin fails++; $display("FAIL here_reload got %0d cycles expected %0d", openc, TP); end
   endtask

   task automatic test_capacity();
      int exp_q[4] = '{1, 2, 3, 3};
      bit exp_a[4] = '{0, 0, 1, 1};
      do_reset();
      step(4'b0001, 0, 0);
      for (int k = 0; k < 4; k++) begin
         step('0, 1, 0);
         checks++;
         if (qtd !== 2'(exp_q[k]) || alerta !== exp_a[k] || porta !== 1'b1) begin
            fails++;
            $display("FAIL cap_entra k=%0d got qtd=%0d alerta=%b porta=%b expected %0d/%b/1",
                     k, qtd, alerta, porta, exp_q[k], exp_a[k]);
         end
      end
      step('0, 0, 1);
      checks++;
      if (qtd !== 2'd2 || alerta !== 1'b0) begin
         fails++; $display("FAIL cap_sai got qtd=%0d alerta=%b expected 2/0", qtd, alerta);
      end
      step('0, 1, 1);
      checks++;
      if (qtd !== 2'd2) begin fails++; $display("FAIL cap_both got qtd=%0d expected 2", qtd); end
      checks++;
      if (obs !== exp_vec()) begin
         fails++; $display("FAIL cap_model got %b expected %b", obs, exp_vec());
      end
   endtask

   task automatic test_ignored();
      int  openc = 0;
      bit  found = 0;
      do_reset();
      step(4'b0100, 0, 0);
      step('0, 1, 0);
      checks++;
      if (qtd !== 2'd0 || sub !== 1'b1) begin
         fails++; $display("FAIL ign_moving got qtd=%0d subindo=%b expected 0/1", qtd, sub);
      end
      for (int k = 0; k < 20 && !found; k++) begin
         step('0, 0, 0);
         if (porta) found = 1;
      end
      checks++;
      if (!found) begin fails++; $display("FAIL ign_arrive got porta=0 expected 1 within 20 cycles"); end
      openc = 1;
      for (int k = 0; k < 20; k++) begin
         step('0, 0, (k == 0));
         checks++;
         if (obs !== exp_vec()) begin
            fails++; $display("FAIL ign_model k=%0d got %b expected %b", k, obs, exp_vec());
         end
         if (porta) openc++;
         else break;
      end
      checks++;
      if (openc != TP || qtd !== 2'd0) begin
         fails++; $display("FAIL ign_sai_empty got open=%0d qtd=%0d expected %0d/0", openc, qtd, TP);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(4'b1100, 0, 0);
      for (int k = 0; k < 5; k++) step('0, 0, 0);
      checks++;
      if (obs !== exp_vec() || andar !== 2'd1 || pend !== 4'b1100) begin
         fails++; $display("FAIL arst_pre got %b expected %b", obs, exp_vec());
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (andar !== 2'd0 || pend !== 4'b0000 || par !== 1'b1 || sub !== 1'b0) begin
         fails++;
         $display("FAIL arst_now got andar=%0d pend=%b parado=%b subindo=%b expected 0/0000/1/0",
                  andar, pend, par, sub);
      end
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      step('0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
         fails++; $display("FAIL arst_after got %b expected %b", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [N-1:0] ch;
      bit           en;
      bit           sa;
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         ch = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 15)) : '0;
         en = ($urandom_range(0, 3) == 0);
         sa = ($urandom_range(0, 4) == 0);
         step(ch, en, sa);
         checks++;
         if (obs !== exp_vec()) begin
            fails++; $display("FAIL rand_model k=%0d got %b expected %b", k, obs, exp_vec());
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      chamada = '0;
      entra   = 1'b0;
      sai     = 1'b0;
      model_reset();
      test_reset();
      test_up_travel();
      test_direction_memory();
      test_current_floor();
      test_capacity();
      test_ignored();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
